// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - shared field widths, state encoding and operand layout for the fp8 adder
package fp8_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp8_t;

endpackage

// File: rtl/fp8_norm_step.sv
// rtl/fp8_norm_step.sv - one normalization decision on the carry-extended working mantissa
module fp8_norm_step
    import fp8_pkg::*;
#(
    parameter int GUARD = 3,
    localparam int MW = FRAC_W + 1 + GUARD
) (
    input  logic [MW:0]      mant,
    input  logic [EXP_W-1:0] exp,
    input  logic             sign,
    output logic [MW:0]      next_mant,
    output logic [EXP_W-1:0] next_exp,
    output logic             done,
    output logic             ovf,
    output logic             unf,
    output logic [7:0]       res
);

    // Bit MW is the carry out of the add, bit MW-1 the hidden one.
    always_comb begin
        next_mant = mant;
        next_exp  = exp;
        done      = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        res       = 8'h00;
        if (mant[MW]) begin
            if (exp == EXP_MAX) begin
                done = 1'b1;
                ovf  = 1'b1;
                res  = {sign, EXP_MAX, {FRAC_W{1'b1}}};
            end else begin
                next_mant = mant >> 1;
                next_exp  = exp + 1'b1;
            end
        end else if (mant == '0) begin
            done = 1'b1;
        end else if (mant[MW-1]) begin
            done = 1'b1;
            res  = {sign, exp, mant[MW-2 -: FRAC_W]};
        end else if (exp == '0) begin
            done = 1'b1;
            unf  = 1'b1;
        end else begin
            next_mant = mant << 1;
            next_exp  = exp - 1'b1;
        end
    end

endmodule

// File: rtl/fp8_add_seq.sv
// rtl/fp8_add_seq.sv - multi-cycle fp8 adder: align, add and normalize one step per clock
module fp8_add_seq
    import fp8_pkg::*;
#(
    parameter int GUARD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] res,
    output logic       ovf,
    output logic       unf,
    output logic       busy
);

    localparam int MW = FRAC_W + 1 + GUARD;

    state_t           state;
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MW-1:0]    mant_a, mant_b;
    logic             sum_sign;
    logic [EXP_W-1:0] sum_exp;
    logic [MW:0]      sum_mant;

    fp8_t opa, opb;
    assign opa = op_a;
    assign opb = op_b;

    logic [MW:0]      ext_a, ext_b;
    assign ext_a = {1'b0, mant_a};
    assign ext_b = {1'b0, mant_b};

    logic [MW:0]      nrm_mant;
    logic [EXP_W-1:0] nrm_exp;
    logic             nrm_done, nrm_ovf, nrm_unf;
    logic [7:0]       nrm_res;

    fp8_norm_step #(.GUARD(GUARD)) u_norm (
        .mant      (sum_mant),
        .exp       (sum_exp),
        .sign      (sum_sign),
        .next_mant (nrm_mant),
        .next_exp  (nrm_exp),
        .done      (nrm_done),
        .ovf       (nrm_ovf),
        .unf       (nrm_unf),
        .res       (nrm_res)
    );

    // in_ready is held low while rst is asserted so nothing is taken during reset.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            mant_a   <= '0;
            mant_b   <= '0;
            sum_sign <= 1'b0;
            sum_exp  <= '0;
            sum_mant <= '0;
            res      <= 8'h00;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_a <= opa.sign;
                        sign_b <= opb.sign;
                        exp_a  <= opa.exp;
                        exp_b  <= opb.exp;
                        mant_a <= {(opa.exp != '0) || (opa.frac != '0), opa.frac, {GUARD{1'b0}}};
                        mant_b <= {(opb.exp != '0) || (opb.frac != '0), opb.frac, {GUARD{1'b0}}};
                        res    <= 8'h00;
                        ovf    <= 1'b0;
                        unf    <= 1'b0;
                        state  <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (exp_a == exp_b) begin
                        state <= ST_ADD;
                    end else if (exp_a < exp_b) begin
                        mant_a <= mant_a >> 1;
                        exp_a  <= exp_a + 1'b1;
                    end else begin
                        mant_b <= mant_b >> 1;
                        exp_b  <= exp_b + 1'b1;
                    end
                end
                ST_ADD: begin
                    sum_exp <= exp_a;
                    if (sign_a == sign_b) begin
                        sum_mant <= ext_a + ext_b;
                        sum_sign <= sign_a;
                    end else if (mant_a >= mant_b) begin
                        sum_mant <= ext_a - ext_b;
                        sum_sign <= (mant_a == mant_b) ? 1'b0 : sign_a;
                    end else begin
                        sum_mant <= ext_b - ext_a;
                        sum_sign <= sign_b;
                    end
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (nrm_done) begin
                        res   <= nrm_res;
                        ovf   <= nrm_ovf;
                        unf   <= nrm_unf;
                        state <= ST_DONE;
                    end else begin
                        sum_mant <= nrm_mant;
                        sum_exp  <= nrm_exp;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp8_add_seq.md
# fp8_add_seq

Multi-cycle sequencer for the 8-bit floating-point adder datapath: sign, 3-bit exponent, 4-bit fraction with implicit leading one. Accepts one operand pair per transaction over a valid/ready handshake, then walks it through align, add and normalize one step per clock. Returns a packed 8-bit result with overflow/underflow flags. Replaces single-cycle combinational normalization, so the datapath can close timing and feed a pipelined consumer.

## Interface
- GUARD, 3, guard bits kept below the fraction during alignment; working mantissa width is 5+GUARD.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept; high only in IDLE
- op_a  in  8  operand A: [7] sign, [6:4] exponent, [3:0] fraction
- op_b  in  8  operand B, same format
- out_valid  out  1  res/ovf/unf valid; high only in DONE
- out_ready  in  1  consumer accepts result
- res  out  8  packed sum
- ovf  out  1  exponent overflow, result saturated
- unf  out  1  underflow, result flushed to zero
- busy  out  1  high in every state except IDLE

## Operation
- Operand decode: hidden bit = (op[6:0] != 0), so 8'h00 and 8'h80 are zero. Working mantissa = {hidden, frac, GUARD zeros}. One extra carry bit is kept on the sum.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE: in_ready=1. On in_valid, latch sign/exp/mantissa of both operands, then go to ALIGN.
- ALIGN, one action per cycle:
  - If exponents are equal, go to ADD.
  - Otherwise shift the mantissa of the smaller-exponent operand right by 1 and increment its exponent. Bits shifted past the LSB are dropped.
- ADD, one cycle:
  - Same signs: add the magnitudes; result sign is the common sign.
  - Different signs: subtract the smaller magnitude from the larger; sign of the larger.
  - Equal magnitudes give +0.
  - Go to NORM.
- NORM, one action per cycle, in priority order:
  - Carry set and exp==7: saturate to {sign,3'b111,4'b1111}, set ovf, go to DONE.
  - Carry set: shift right 1, exp+1, stay in NORM.
  - Mantissa zero: res=8'h00, go to DONE.
  - Bit [4+GUARD] set: pack {sign, exp, mantissa[3+GUARD:GUARD]} with truncation (no rounding), go to DONE.
  - exp==0: res=8'h00, set unf, go to DONE.
  - Otherwise: shift left 1, exp-1, stay in NORM.
- DONE: out_valid=1; res/ovf/unf stable. On out_ready go to IDLE. in_valid is ignored here.
- ovf/unf describe the current result only and are cleared on the next accept.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 after; out_valid=0; res=8'h00; ovf=0; unf=0; busy=0; state=IDLE.
- rst in any state aborts the transaction next edge. No result is emitted and latched operands are discarded.
- Latency from the accept edge to the first cycle with out_valid high = d+k+4 cycles.
  - d = |expA-expB|.
  - k = number of NORM shift cycles.
  - Minimum is 4 (d=0, k=0). Maximum is 7+1+(4+GUARD)+3 bounded, with no hang.
- Throughput: one transaction in flight. in_ready is low from the accept edge until the cycle after the out_valid&out_ready handshake.
- Outputs are registered; no combinational path from in_valid or out_ready to any output.

## Structure
- Package fp8_pkg holds:
  - field widths (SIGN_W=1, EXP_W=3, FRAC_W=4);
  - EXP_MAX=3'd7;
  - the state enum;
  - a packed operand struct {sign, exp, frac}.
- One sub-module is natural: fp8_norm_step. It is combinational and covers a single NORM decision:
  - inputs: mantissa, exp, sign;
  - outputs: next mantissa, next exp, done, ovf, unf, packed result.
- Instantiate fp8_norm_step once, inside the NORM state logic.

## Test plan
- 0x30+0x30 (1.0+1.0) -> res=0x40, ovf=0, out_valid 5 cycles after accept (one NORM right shift).
- 0x35+0x10 (d=2) -> res=0x39, out_valid 6 cycles after accept.
- 0x30+0xB0 -> res=0x00, sign positive, ovf=unf=0, out_valid 4 cycles after accept.
- 0x7F+0x7F -> res=0x7F, ovf=1, 4 cycles; next transaction 0x30+0x30 shows ovf=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 10 cycles with in_valid=1 and new operands.
  - res stays constant, in_ready=0, and the second pair is accepted only after the handshake.
- Assert rst in ALIGN of a d=5 transaction.
  - Next cycle: out_valid=0, busy=0, in_ready=1.
  - A following 0x30+0x30 returns 0x40 with normal latency.
